// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder backed by a local 32-bit register bank.
// Accepts one read address at a time on AR. After a programmable latency it
// returns the register contents (or an error response) on R.
// The bank is written from the fabric side through a simple local write port.
//
// Ports:
//   ACLK, ARESET            clock, asynchronous active-high reset
//   ARVALID/ARREADY/ARADDR  read-address channel (ARPROT accepted, ignored)
//   RVALID/RREADY           read-data channel handshake
//   RDATA/RRESP             read data and response (OKAY/SLVERR/DECERR)
//   wr_en/wr_idx/wr_data    local register write port
module axi_lite_read_slave #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  input  logic              wr_en,
  input  logic [ADDR_W-3:0] wr_idx,
  input  logic [31:0]       wr_data
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        regs [NUM_REGS];

  logic               ar_hs;
  logic [ADDR_W-1:0]  dec_addr;
  logic [IDX_W-1:0]   dec_idx;
  logic [31:0]        rd_word;
  logic [31:0]        dec_data;
  logic [1:0]         dec_resp;

  // ARPROT carries no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^ARPROT;

  assign ARREADY = (state == IDLE) && !ARESET;
  assign ar_hs   = ARVALID && ARREADY;

  // Capture happens in IDLE only when latency is zero, using the live address.
  always_comb begin
    dec_addr = (state == IDLE) ? ARADDR : addr_q;
    dec_idx  = dec_addr[ADDR_W-1:2];
    rd_word  = 32'h0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(dec_idx) == i) rd_word = regs[i];
    end
    if (dec_addr[1:0] != 2'b00) begin
      dec_data = 32'h0;
      dec_resp = RESP_SLVERR;
    end else if (32'(dec_idx) >= NUM_REGS) begin
      dec_data = 32'h0;
      dec_resp = RESP_DECERR;
    end else begin
      dec_data = rd_word;
      dec_resp = RESP_OKAY;
    end
  end

  // Read FSM: IDLE -> (WAIT) -> RESP -> IDLE.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt    <= '0;
      RVALID <= 1'b0;
      RDATA  <= 32'h0;
      RRESP  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q <= ARADDR;
            if (READ_LATENCY == 0) begin
              state  <= RESP;
              RVALID <= 1'b1;
              RDATA  <= dec_data;
              RRESP  <= dec_resp;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(READ_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= RESP;
            RVALID <= 1'b1;
            RDATA  <= dec_data;
            RRESP  <= dec_resp;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (RREADY) begin
            state  <= IDLE;
            RVALID <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          RVALID <= 1'b0;
        end
      endcase
    end
  end

  // Register bank; a write on the capture edge is not seen by that capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (32'(wr_idx) == i) regs[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_read_slave.sv
module tb_axi_lite_read_slave;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NREGS  = 8;
  localparam int          LAT    = 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              wr_en;
  logic [ADDR_W-3:0] wr_idx;
  logic [31:0]       wr_data;

  axi_lite_read_slave #(
    .ADDR_W(ADDR_W), .NUM_REGS(NREGS), .READ_LATENCY(LAT)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    int          stall;   // cycles of RREADY=0 after RVALID rises
    int          wr_at;   // edge index (0 = AR handshake edge) of a local write, -1 none
    logic [5:0]  widx;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [5:0] idx, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_data = d;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic edge_step(input int e, input int wr_at, input logic [5:0] widx,
                           input logic [31:0] wdata);
    wr_en = (e == wr_at); wr_idx = widx; wr_data = wdata;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_txn(input vec_t v);
    int   e;
    exp_t ex;
    ARADDR  = v.addr;
    ARVALID = 1'b1;
    RREADY  = (v.stall == 0);
    chk("arready_idle", 32'(ARREADY), 32'd1);
    sb.push_back('{data: v.exp_data, resp: v.exp_resp});
    e = 0;
    do begin
      edge_step(e, v.wr_at, v.widx, v.wdata);
      ARVALID = 1'b0;
      e++;
    end while (!RVALID && e < 40);
    if (!RVALID) begin
      chk("rvalid_timeout", 32'(RVALID), 32'd1);
      sb.delete();
      return;
    end
    chk("latency", 32'(e - 1), 32'(LAT));
    chk("arready_resp", 32'(ARREADY), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    ex = sb.pop_front();
    chk("rdata", RDATA, ex.data);
    chk("rresp", 32'(RRESP), 32'(ex.resp));
    for (int s = 0; s < v.stall; s++) begin
      edge_step(e, v.wr_at, v.widx, v.wdata);
      e++;
      chk("stall_rvalid", 32'(RVALID), 32'd1);
      chk("stall_rdata", RDATA, ex.data);
      chk("stall_rresp", 32'(RRESP), 32'(ex.resp));
      chk("stall_arready", 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    edge_step(e, v.wr_at, v.widx, v.wdata);
    chk("rvalid_after_hs", 32'(RVALID), 32'd0);
    chk("arready_after_hs", 32'(ARREADY), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    ARESET = 1'b1; ARVALID = 1'b0; ARADDR = '0; ARPROT = 3'b000;
    RREADY = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      chk("rst_arready", 32'(ARREADY), 32'd0);
      chk("rst_rvalid", 32'(RVALID), 32'd0);
    end
    ARESET = 1'b0;
    #1;
    chk("idle_arready", 32'(ARREADY), 32'd1);
    chk("idle_rvalid", 32'(RVALID), 32'd0);
    chk("idle_rdata", RDATA, 32'h0);
    chk("idle_rresp", 32'(RRESP), 32'd0);

    do_write(6'd3, 32'hDEADBEEF);
    do_write(6'd1, 32'h0000_0001);
    do_write(6'd0, 32'hA5A5_0000);
    do_write(6'd7, 32'h7777_7777);
    do_write(6'd8, 32'hBAD0_BAD0);   // out of range, must be dropped

    //            addr   stall wr_at widx  wdata          exp_data       resp
    vecs.push_back('{8'h0C, 0, -1, 6'd0, 32'h0,         32'hDEADBEEF, 2'b00});
    vecs.push_back('{8'h0C, 5, -1, 6'd0, 32'h0,         32'hDEADBEEF, 2'b00});
    vecs.push_back('{8'h0D, 0, -1, 6'd0, 32'h0,         32'h0,        2'b10});
    vecs.push_back('{8'h20, 0, -1, 6'd0, 32'h0,         32'h0,        2'b11});
    vecs.push_back('{8'h1C, 0, -1, 6'd0, 32'h0,         32'h7777_7777, 2'b00});
    vecs.push_back('{8'h00, 0, -1, 6'd0, 32'h0,         32'hA5A5_0000, 2'b00});
    vecs.push_back('{8'h02, 1, -1, 6'd0, 32'h0,         32'h0,        2'b10});
    vecs.push_back('{8'hFC, 0, -1, 6'd0, 32'h0,         32'h0,        2'b11});
    vecs.push_back('{8'h04, 0, LAT, 6'd1, 32'h2,        32'h1,        2'b00});
    vecs.push_back('{8'h04, 0, -1, 6'd0, 32'h0,         32'h2,        2'b00});
    vecs.push_back('{8'h08, 0, 1,  6'd2, 32'h22,        32'h22,       2'b00});
    vecs.push_back('{8'h08, 3, LAT+1, 6'd2, 32'h33,     32'h22,       2'b00});
    vecs.push_back('{8'h08, 0, -1, 6'd0, 32'h0,         32'h33,       2'b00});
    vecs.push_back('{8'h14, 0, -1, 6'd0, 32'h0,         32'h0,        2'b00});

    foreach (vecs[i]) read_txn(vecs[i]);

    // Reset while holding a response under backpressure
    ARADDR = 8'h0C; ARVALID = 1'b1; RREADY = 1'b0;
    n = 0;
    do begin
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      n++;
    end while (!RVALID && n < 40);
    chk("midrst_rvalid_before", 32'(RVALID), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(RVALID), 32'd0);
    chk("midrst_arready", 32'(ARREADY), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    RREADY = 1'b1;
    #1;
    chk("midrst_idle", 32'(ARREADY), 32'd1);
    read_txn('{8'h0C, 0, -1, 6'd0, 32'h0, 32'h0, 2'b00});
    read_txn('{8'h1C, 0, -1, 6'd0, 32'h0, 32'h0, 2'b00});

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
